// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   loader_state_e  : loader FSM states (3-bit encoding)
//   IMEM_BYTE_LANES : byte lanes per instruction word
//   LANE_W          : width of the byte-lane index
//   count_exceeds() : frame word count larger than the target memory
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_COUNT = 3'd1,
    GET_BYTES = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } loader_state_e;

  localparam int IMEM_BYTE_LANES = 4;
  localparam int LANE_W          = $clog2(IMEM_BYTE_LANES);

  function automatic logic count_exceeds(input logic [7:0] n, input int depth);
    return int'({24'h0, n}) > depth;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle timer for the loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : timer runs only while high; held reloaded otherwise
//   kick       : a byte arrived, restart the idle interval
//   expired    : TIMEOUT_CYC cycles have passed since the last kick/enable
// TIMEOUT_CYC = 0 disables expiry entirely.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Loaded on the kick edge and decremented on each following edge, so the
  // count hits zero in the TIMEOUT_CYC-th cycle and the owner reacts on the
  // edge exactly TIMEOUT_CYC cycles after the kick.
  localparam logic [CNT_W-1:0] RELOAD =
    (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || kick) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && enable && !kick && (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// Write-side loader for the instruction memory.
// Receives a framed program image from the UART receiver (count byte N, then
// 4*N little-endian payload bytes) and writes it one byte per cycle through
// the memory's byte-lane write port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a load (honoured in IDLE, DONE, ERROR)
//   rx_data        : received byte
//   rx_valid       : rx_data strobe, no backpressure
//   imem_wr_en     : one-cycle write strobe
//   imem_addr      : byte address {word, lane}
//   imem_data      : {24'h0, byte}
//   busy           : loading (GET_COUNT, GET_BYTES)
//   done / err     : sticky result flags until the next start
//   words_loaded   : complete words written in the current/last load
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | after reset, waiting for start
// GET_COUNT | waiting for the word-count byte
// GET_BYTES | writing payload bytes until 4*N have been written
// DONE      | load finished, done held until next start
// ERROR     | oversize count or inter-byte timeout, err held
module imem_loader
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH   = 64,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        imem_wr_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  words_loaded
);

  localparam int WORD_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra value so the counter can reach N == MEM_DEPTH.
  localparam int WORD_CNT_W = $clog2(MEM_DEPTH + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(IMEM_BYTE_LANES - 1);

  loader_state_e state_q, state_nxt;

  logic [WORD_CNT_W-1:0] n_words_q;
  logic [WORD_CNT_W-1:0] word_cnt_q;
  logic [LANE_W-1:0]     byte_cnt_q;

  logic latch_n;
  logic accept_byte;
  logic clear_words;
  logic timer_expired;

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .kick   (rx_valid),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    latch_n     = 1'b0;
    accept_byte = 1'b0;
    clear_words = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt   = GET_COUNT;
          clear_words = 1'b1;
        end
      end
      GET_COUNT: begin
        if (rx_valid) begin
          if (rx_data == 8'd0) begin
            state_nxt = DONE;
          end else if (count_exceeds(rx_data, MEM_DEPTH)) begin
            state_nxt = ERROR;
          end else begin
            latch_n   = 1'b1;
            state_nxt = GET_BYTES;
          end
        end else if (timer_expired) begin
          state_nxt = ERROR;
        end
      end
      GET_BYTES: begin
        // word_cnt reaches N on the edge that registers the final write, so
        // this branch fires during the final strobe and DONE follows it.
        // Any byte arriving in that cycle is beyond the frame and dropped.
        if (word_cnt_q == n_words_q) begin
          state_nxt = DONE;
        end else if (rx_valid) begin
          accept_byte = 1'b1;
        end else if (timer_expired) begin
          state_nxt = ERROR;
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_nxt   = GET_COUNT;
          clear_words = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= '0;
      n_words_q    <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      words_loaded <= '0;
    end else begin
      imem_wr_en <= accept_byte;
      if (accept_byte) begin
        imem_addr  <= 32'({word_cnt_q[WORD_IDX_W-1:0], byte_cnt_q});
        imem_data  <= {24'h0, rx_data};
        byte_cnt_q <= byte_cnt_q + 1'b1;
        if (byte_cnt_q == LAST_LANE) begin
          word_cnt_q   <= word_cnt_q + 1'b1;
          words_loaded <= words_loaded + 8'd1;
        end
      end
      if (latch_n) begin
        n_words_q  <= WORD_CNT_W'(rx_data);
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
      end
      if (clear_words) begin
        words_loaded <= '0;
      end
    end
  end

  assign busy = (state_q == GET_COUNT) || (state_q == GET_BYTES);
  assign done = (state_q == DONE);
  assign err  = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (MEM_DEPTH=64, TIMEOUT_CYC=50).
// Expected writes are derived from the frame itself: payload byte i lands at
// byte address i with data {24'h0, byte}, and words_loaded is N.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        imem_wr_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  payload[$];

  imem_loader #(
    .MEM_DEPTH  (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .imem_wr_en  (imem_wr_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst_n && imem_wr_en) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
      wr_cyc_q.push_back(cyc);
      mem[imem_addr[7:0]] = imem_data[7:0];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic wait_end(input int budget, output int used);
    used = 0;
    while (!(done || err) && used < budget) begin
      @(negedge clk);
      used++;
    end
  endtask

  task automatic send_frame(input logic [7:0] n, input int maxgap);
    send_byte(n, $urandom_range(0, maxgap));
    foreach (payload[i]) send_byte(payload[i], $urandom_range(0, maxgap));
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({imem_wr_en, busy, done, err} !== 4'b0 || imem_addr !== 32'h0 ||
        imem_data !== 32'h0 || words_loaded !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs got wr=%b busy=%b done=%b err=%b addr=%h data=%h words=%0d exp all 0",
               imem_wr_en, busy, done, err, imem_addr, imem_data, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    clear_log();
    send_byte(8'h02, 1);
    send_byte(8'h77, 3);
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_rx_ignored got writes=%0d busy=%b exp 0 0", wr_addr_q.size(), busy);
    end
  endtask

  task automatic test_basic();
    int used;
    clear_log();
    pulse_start();
    payload = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_frame(8'h02, 2);
    wait_end(40, used);
    tick(2);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 8'd2) begin
      failures++;
      $display("FAIL basic_flags got done=%b err=%b words=%0d exp 1 0 2", done, err, words_loaded);
    end
    checks++;
    if (wr_addr_q.size() !== 8) begin
      failures++;
      $display("FAIL basic_count got %0d exp 8", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== {24'h0, payload[i]}) begin
          failures++;
          $display("FAIL basic_write%0d got addr=%h data=%h exp addr=%h data=%h",
                   i, wr_addr_q[i], wr_data_q[i], i, {24'h0, payload[i]});
        end
      end
    end
    checks++;
    if ({mem[3], mem[2], mem[1], mem[0]} !== 32'h00000013 ||
        {mem[7], mem[6], mem[5], mem[4]} !== 32'h00100093) begin
      failures++;
      $display("FAIL basic_words got w0=%h w1=%h exp 00000013 00100093",
               {mem[3], mem[2], mem[1], mem[0]}, {mem[7], mem[6], mem[5], mem[4]});
    end
    // Bytes arriving while DONE must not write or disturb the result.
    clear_log();
    send_byte(8'hEE, 0);
    send_byte(8'hDD, 2);
    checks++;
    if (wr_addr_q.size() !== 0 || done !== 1'b1 || words_loaded !== 8'd2) begin
      failures++;
      $display("FAIL done_rx_ignored got writes=%0d done=%b words=%0d exp 0 1 2",
               wr_addr_q.size(), done, words_loaded);
    end
  endtask

  task automatic test_zero_count();
    int used;
    clear_log();
    pulse_start();
    checks++;
    if (words_loaded !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear got words=%0d busy=%b done=%b exp 0 1 0", words_loaded, busy, done);
    end
    send_byte(8'h00, 0);
    wait_end(10, used);
    tick(3);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 8'd0 || wr_addr_q.size() !== 0) begin
      failures++;
      $display("FAIL zero_count got done=%b err=%b words=%0d writes=%0d exp 1 0 0 0",
               done, err, words_loaded, wr_addr_q.size());
    end
  endtask

  task automatic test_oversize();
    int used;
    logic [7:0] big;
    for (int k = 0; k < 2; k++) begin
      big = (k == 0) ? 8'h41 : 8'($urandom_range(DEPTH + 1, 255));
      clear_log();
      pulse_start();
      send_byte(big, 0);
      wait_end(10, used);
      tick(3);
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || wr_addr_q.size() !== 0) begin
        failures++;
        $display("FAIL oversize_%0d got err=%b done=%b writes=%0d exp 1 0 0",
                 big, err, done, wr_addr_q.size());
      end
    end
    clear_log();
    pulse_start();
    payload = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    send_frame(8'h01, 3);
    wait_end(40, used);
    tick(2);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 8'd1 || wr_addr_q.size() !== 4) begin
      failures++;
      $display("FAIL after_error_load got done=%b err=%b words=%0d writes=%0d exp 1 0 1 4",
               done, err, words_loaded, wr_addr_q.size());
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_log();
    pulse_start();
    send_byte(8'h01, 3);
    send_byte(8'hAA, 2);
    send_byte(8'hBB, 0);
    k = 0;
    while (!err && k < 2 * TMO) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== TMO) begin
      failures++;
      $display("FAIL timeout_latency got %0d cycles exp %0d", k, TMO);
    end
    tick(2);
    checks++;
    if (err !== 1'b1 || words_loaded !== 8'd0 || wr_addr_q.size() !== 2) begin
      failures++;
      $display("FAIL timeout_state got err=%b words=%0d writes=%0d exp 1 0 2",
               err, words_loaded, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'd0 || wr_addr_q[1] !== 32'd1 ||
          wr_data_q[0] !== 32'h0000_00AA || wr_data_q[1] !== 32'h0000_00BB) begin
        failures++;
        $display("FAIL timeout_writes got %h:%h %h:%h exp 0:aa 1:bb",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_start();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    send_byte(8'h02, 0);
    foreach (payload[i]) send_byte(payload[i], 0);
    // Final strobe is visible now; DONE must follow in the next cycle.
    checks++;
    if (imem_wr_en !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL last_strobe got wr=%b done=%b exp 1 0", imem_wr_en, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || imem_wr_en !== 1'b0 || words_loaded !== 8'd2) begin
      failures++;
      $display("FAIL done_after_strobe got done=%b wr=%b words=%0d exp 1 0 2", done, imem_wr_en, words_loaded);
    end
    tick(1);
    checks++;
    if (wr_addr_q.size() !== 8) begin
      failures++;
      $display("FAIL b2b_count got %0d exp 8", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_cyc_q[i] !== wr_cyc_q[0] + i || wr_addr_q[i] !== 32'(i) ||
            wr_data_q[i] !== {24'h0, payload[i]}) begin
          failures++;
          $display("FAIL b2b_write%0d got cyc_off=%0d addr=%h data=%h exp %0d %h %h",
                   i, wr_cyc_q[i] - wr_cyc_q[0], wr_addr_q[i], wr_data_q[i], i, i, {24'h0, payload[i]});
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int used;
    clear_log();
    pulse_start();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    send_byte(8'h02, 1);
    for (int i = 0; i < 3; i++) send_byte(payload[i], 1);
    pulse_start();
    for (int i = 3; i < 8; i++) send_byte(payload[i], 1);
    wait_end(20, used);
    tick(2);
    checks++;
    if (done !== 1'b1 || words_loaded !== 8'd2 || wr_addr_q.size() !== 8) begin
      failures++;
      $display("FAIL start_busy got done=%b words=%0d writes=%0d exp 1 2 8",
               done, words_loaded, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[7] !== 32'd7 || wr_data_q[7] !== {24'h0, payload[7]}) begin
        failures++;
        $display("FAIL start_busy_last got addr=%h data=%h exp 7 %h", wr_addr_q[7], wr_data_q[7], payload[7]);
      end
    end
  endtask

  task automatic test_random_frames();
    int used;
    int n;
    int bad;
    for (int f = 0; f < 5; f++) begin
      n = (f == 0) ? DEPTH : $urandom_range(1, 6);
      payload.delete();
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
      clear_log();
      pulse_start();
      send_frame(8'(n), 3);
      wait_end(100, used);
      tick(2);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 8'(n) || wr_addr_q.size() !== 4 * n) begin
        failures++;
        $display("FAIL rand_frame%0d got done=%b err=%b words=%0d writes=%0d exp 1 0 %0d %0d",
                 f, done, err, words_loaded, wr_addr_q.size(), n, 4 * n);
      end else begin
        bad = 0;
        for (int i = 0; i < 4 * n; i++) begin
          if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== {24'h0, payload[i]}) begin
            if (bad == 0)
              $display("FAIL rand_frame%0d_write%0d got addr=%h data=%h exp %h %h",
                       f, i, wr_addr_q[i], wr_data_q[i], i, {24'h0, payload[i]});
            bad++;
          end
        end
        checks++;
        if (bad != 0) failures++;
      end
    end
  endtask

  task automatic test_reset_midload();
    int used;
    clear_log();
    pulse_start();
    send_byte(8'h02, 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    checks++;
    if (busy !== 1'b1 || imem_wr_en !== 1'b1 || imem_addr !== 32'd2) begin
      failures++;
      $display("FAIL pre_reset got busy=%b wr=%b addr=%h exp 1 1 2", busy, imem_wr_en, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_wr_en, busy, done, err} !== 4'b0 || imem_addr !== 32'h0 ||
        imem_data !== 32'h0 || words_loaded !== 8'h0) begin
      failures++;
      $display("FAIL async_reset got wr=%b busy=%b done=%b err=%b addr=%h data=%h words=%0d exp all 0",
               imem_wr_en, busy, done, err, imem_addr, imem_data, words_loaded);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_log();
    send_byte(8'h44, 0);
    send_byte(8'h55, 3);
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_after_reset got writes=%0d busy=%b exp 0 0", wr_addr_q.size(), busy);
    end
    // start and a zero byte together in IDLE: the byte must not count as N.
    start    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_rx_same_cycle got busy=%b done=%b exp 1 0", busy, done);
    end
    payload = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    send_frame(8'h01, 2);
    wait_end(30, used);
    tick(2);
    checks++;
    if (done !== 1'b1 || words_loaded !== 8'd1 || wr_addr_q.size() !== 4) begin
      failures++;
      $display("FAIL fresh_load got done=%b words=%0d writes=%0d exp 1 1 4",
               done, words_loaded, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== {24'h0, payload[0]} ||
          wr_addr_q[3] !== 32'd3 || wr_data_q[3] !== {24'h0, payload[3]}) begin
        failures++;
        $display("FAIL fresh_load_data got %h:%h %h:%h exp 0:%h 3:%h",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[3], wr_data_q[3], payload[0], payload[3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_oversize();
    test_timeout();
    test_back_to_back();
    test_start_while_busy();
    test_random_frames();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
